// File: rtl/tmp_meas_sched.sv
// Measurement scheduler: round-robin arbitration of two requesters onto one
// temperature converter core, with warm-up, sample averaging and timeout.
module tmp_meas_sched #(
    parameter int CODE_W   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int WARM_CYC = 4,
    parameter int TMO_W    = 10,
    parameter int TMO_CYC  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_i,
    output logic [1:0]        ack_o,
    output logic              err_o,
    output logic [CODE_W-1:0] result_o,
    output logic              busy_o,
    output logic              core_rst_o,
    input  logic              core_valid_i,
    input  logic [CODE_W-1:0] core_code_i
);

    localparam int ACC_W  = CODE_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int WARM_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

    localparam logic [CNT_W-1:0]  LAST_SMP  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WARM_W-1:0] LAST_WARM = WARM_W'(WARM_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LIM   = TMO_W'(TMO_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               grant_reg, grant_next;
    logic               ptr_reg, ptr_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WARM_W-1:0]  warm_reg, warm_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    logic [1:0]         ack_reg, ack_next;
    logic               err_reg, err_next;
    logic [CODE_W-1:0]  result_reg, result_next;
    logic               busy_reg, busy_next;
    logic               core_rst_reg, core_rst_next;

    logic               req_any;
    logic               sel_idx;
    logic               warm_last;
    logic               smp_last;
    logic               tmo_hit;
    logic [TMO_W-1:0]   tmo_inc;
    logic [ACC_W-1:0]   sum;
    logic [1:0]         grant_onehot;

    // Pointer only matters when both requesters ask in the same cycle.
    assign req_any   = |req_i;
    assign sel_idx   = (req_i == 2'b10) ? 1'b1 :
                       (req_i == 2'b01) ? 1'b0 : ptr_reg;
    assign warm_last = (warm_reg == LAST_WARM);
    assign smp_last  = (cnt_reg == LAST_SMP);
    assign tmo_inc   = tmo_reg + 1'b1;
    assign tmo_hit   = (tmo_inc == TMO_LIM);
    assign sum       = acc_reg + ACC_W'(core_code_i);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_reg == 1'(gi));
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            grant_reg    <= 1'b0;
            ptr_reg      <= 1'b0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            warm_reg     <= '0;
            tmo_reg      <= '0;
            ack_reg      <= 2'b00;
            err_reg      <= 1'b0;
            result_reg   <= '0;
            busy_reg     <= 1'b0;
            core_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            warm_reg     <= warm_next;
            tmo_reg      <= tmo_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            result_reg   <= result_next;
            busy_reg     <= busy_next;
            core_rst_reg <= core_rst_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req_any) state_next = S_WARM;
            S_WARM: if (warm_last) state_next = S_CONV;
            S_CONV: if ((core_valid_i && smp_last) || (!core_valid_i && tmo_hit))
                        state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        warm_next     = warm_reg;
        tmo_next      = tmo_reg;
        ack_next      = ack_reg;
        err_next      = err_reg;
        result_next   = result_reg;
        busy_next     = busy_reg;
        core_rst_next = core_rst_reg;
        case (state_reg)
            S_IDLE: begin
                core_rst_next = 1'b1;
                if (req_any) begin
                    grant_next = sel_idx;
                    busy_next  = 1'b1;
                    acc_next   = '0;
                    cnt_next   = '0;
                    warm_next  = '0;
                end
            end
            S_WARM: begin
                warm_next = warm_reg + 1'b1;
                if (warm_last) begin
                    core_rst_next = 1'b0;
                    tmo_next      = '0;
                end
            end
            S_CONV: begin
                // A valid sample always beats a coincident timeout.
                if (core_valid_i) begin
                    tmo_next = '0;
                    if (smp_last) begin
                        result_next   = sum[ACC_W-1 -: CODE_W];
                        ack_next      = grant_onehot;
                        core_rst_next = 1'b1;
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (tmo_hit) begin
                    ack_next      = grant_onehot;
                    err_next      = 1'b1;
                    core_rst_next = 1'b1;
                end else begin
                    tmo_next = tmo_inc;
                end
            end
            S_DONE: begin
                ack_next  = 2'b00;
                err_next  = 1'b0;
                busy_next = 1'b0;
                ptr_next  = ~grant_reg;
            end
            default: ;
        endcase
    end

    assign ack_o      = ack_reg;
    assign err_o      = err_reg;
    assign result_o   = result_reg;
    assign busy_o     = busy_reg;
    assign core_rst_o = core_rst_reg;

endmodule

// File: tb/tb_tmp_meas_sched.sv
// Directed bench for tmp_meas_sched: table of request/sample vectors plus
// hand sequences for power-on state and reset during a conversion.
module tb_tmp_meas_sched;

    localparam int WARM_CYC = 4;
    localparam int TMO_CYC  = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [1:0] ack_o;
    logic       err_o;
    logic [7:0] result_o;
    logic       busy_o;
    logic       core_rst_o;
    logic       core_valid_i = 1'b0;
    logic [7:0] core_code_i = 8'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tmp_meas_sched #(
        .CODE_W(8), .AVG_LOG2(2), .WARM_CYC(WARM_CYC), .TMO_W(10), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .ack_o(ack_o), .err_o(err_o),
        .result_o(result_o), .busy_o(busy_o), .core_rst_o(core_rst_o),
        .core_valid_i(core_valid_i), .core_code_i(core_code_i)
    );

    typedef struct {
        logic [1:0]      rq;     // request pattern driven
        logic [1:0]      keep;   // request bits left high after the ack
        int              nv;     // valid pulses to send (0 = let it time out)
        int              gap;    // cycles between valid pulses
        logic [3:0][7:0] codes;
        logic [1:0]      eack;
        logic [7:0]      eres;
        logic            eerr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic txn(input string nm, input vec_t v);
        int n;
        @(negedge clk);
        req_i = v.rq;
        n = 0;
        while (!busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_grant"}, 32'(busy_o), 32'd1);
        // A valid during warm-up must not be accumulated.
        core_valid_i = 1'b1;
        core_code_i  = 8'd200;
        n = 0;
        while (core_rst_o && n < 50) begin
            @(negedge clk);
            core_valid_i = 1'b0;
            n++;
        end
        chk({nm, "_warm_len"}, 32'(n), 32'(WARM_CYC));
        if (v.nv > 0) begin
            for (int i = 0; i < v.nv; i++) begin
                repeat (v.gap - 1) @(negedge clk);
                chk($sformatf("%s_rst_low%0d", nm, i), 32'(core_rst_o), 32'd0);
                core_valid_i = 1'b1;
                core_code_i  = v.codes[i];
                if (i == v.nv - 1)
                    chk({nm, "_no_early_ack"}, 32'(ack_o), 32'd0);
                @(negedge clk);
                core_valid_i = 1'b0;
            end
        end else begin
            n = 0;
            while (ack_o == 2'b00 && n < TMO_CYC + 50) begin
                @(negedge clk);
                n++;
            end
            chk({nm, "_tmo_len"}, 32'(n), 32'(TMO_CYC));
        end
        $display("txn %s: ack=%b err=%b result=%0d (exp ack=%b err=%b result=%0d)",
                 nm, ack_o, err_o, result_o, v.eack, v.eerr, v.eres);
        chk({nm, "_ack"}, 32'(ack_o), 32'(v.eack));
        chk({nm, "_err"}, 32'(err_o), 32'(v.eerr));
        chk({nm, "_result"}, 32'(result_o), 32'(v.eres));
        chk({nm, "_core_rst"}, 32'(core_rst_o), 32'd1);
        chk({nm, "_busy_done"}, 32'(busy_o), 32'd1);
        req_i = req_i & v.keep;
        @(negedge clk);
        chk({nm, "_ack_pulse"}, 32'(ack_o), 32'd0);
        chk({nm, "_err_pulse"}, 32'(err_o), 32'd0);
        chk({nm, "_busy_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int  n;
        logic seen;

        // Fairness: both always requesting, served alternately starting with 0.
        vecs[0] = '{2'b11, 2'b10, 4, 1, {8'd6,   8'd3,   8'd2,   8'd1},   2'b01, 8'd3,   1'b0};
        vecs[1] = '{2'b11, 2'b01, 4, 1, {8'd9,   8'd8,   8'd8,   8'd8},   2'b10, 8'd8,   1'b0};
        vecs[2] = '{2'b11, 2'b10, 4, 1, {8'd103, 8'd102, 8'd101, 8'd100}, 2'b01, 8'd101, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 4, 1, {8'd80,  8'd70,  8'd60,  8'd50},  2'b10, 8'd65,  1'b0};
        // Single requester, valid every 20 cycles: 10..13 -> 46/4 = 11.
        vecs[4] = '{2'b01, 2'b00, 4, 20, {8'd13, 8'd12, 8'd11, 8'd10},    2'b01, 8'd11,  1'b0};
        // Truncation: 3/4 -> 0.
        vecs[5] = '{2'b01, 2'b00, 4, 3, {8'd3,   8'd0,   8'd0,   8'd0},   2'b01, 8'd0,   1'b0};
        // Full scale: 1020/4 -> 255.
        vecs[6] = '{2'b01, 2'b00, 4, 2, {8'd255, 8'd255, 8'd255, 8'd255}, 2'b01, 8'd255, 1'b0};
        // Timeout keeps the previous result.
        vecs[7] = '{2'b01, 2'b00, 0, 1, {8'd0,   8'd0,   8'd0,   8'd0},   2'b01, 8'd255, 1'b1};
        // After mid-conversion reset, requester 1 alone.
        vecs[8] = '{2'b10, 2'b00, 4, 1, {8'd4,   8'd4,   8'd4,   8'd4},   2'b10, 8'd4,   1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_core_rst", 32'(core_rst_o), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            txn($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a conversion after two samples.
        @(negedge clk);
        req_i = 2'b01;
        n = 0;
        while (core_rst_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_conv_entry", 32'(core_rst_o), 32'd0);
        repeat (2) begin
            core_valid_i = 1'b1;
            core_code_i  = 8'd9;
            @(negedge clk);
            core_valid_i = 1'b0;
        end
        reset = 1'b1;
        #1;
        $display("txn midrst: ack=%b err=%b result=%0d busy=%b core_rst=%b",
                 ack_o, err_o, result_o, busy_o, core_rst_o);
        chk("midrst_ack", 32'(ack_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_result", 32'(result_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_core_rst", 32'(core_rst_o), 32'd1);
        req_i = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | (|ack_o) | busy_o;
        end
        chk("midrst_no_ack", 32'(seen), 32'd0);

        txn("vec8", vecs[8]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
